// File: rtl/hdlc_pkg.sv
// Shared HDLC constants and the transmit state encoding, used by both Tx and Rx sides.
package hdlc_pkg;

    localparam logic [7:0] FLAG_BYTE  = 8'h7E;  // line order: 0,1,1,1,1,1,1,0
    localparam logic [7:0] ABORT_BYTE = 8'hFE;  // line order: 0 then seven 1s
    localparam int         STUFF_LEN  = 5;      // data ones before a forced 0

    typedef enum logic [2:0] {
        IDLE,
        START_FLAG,
        DATA,
        STUFF,
        END_FLAG,
        ABORT
    } tx_state_t;

endpackage

// File: rtl/hdlc_zero_insert.sv
// Ones-run tracker for transmit zero insertion: asks for a stuffed 0 after
// STUFF_LEN consecutive data ones. The run carries across byte boundaries.
module hdlc_zero_insert
    import hdlc_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic bit_i,       // data bit currently on the line
    input  logic shift_en_i,  // bit_i is a data bit
    input  logic clear_i,     // any non-data bit (stuff, flag, abort, idle)
    output logic stuff_req_o  // bit_i completes the run; next line bit must be 0
);

    localparam logic [2:0] RUN_LAST = 3'(STUFF_LEN - 1);

    logic [2:0] ones_q, ones_d;

    // Next run length: restart on a clear or a data 0, extend on a data 1.
    always_comb begin
        ones_d = ones_q;
        if (clear_i)
            ones_d = 3'd0;
        else if (shift_en_i)
            ones_d = bit_i ? ones_q + 3'd1 : 3'd0;
    end

    // Run length register.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            ones_q <= 3'd0;
        else
            ones_q <= ones_d;
    end

    assign stuff_req_o = shift_en_i && !clear_i && bit_i && (ones_q == RUN_LAST);

endmodule

// File: rtl/hdlc_tx_framer.sv
// Bit-serial HDLC transmit framer: flags, LSB-first data with zero insertion,
// abort on request or underrun, idle ones between frames.
module hdlc_tx_framer
    import hdlc_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tx_Enable,
    input  logic [7:0] Tx_Data,
    input  logic       Tx_DataValid,
    input  logic       Tx_Last,
    input  logic       Tx_AbortFrame,
    output logic       Tx_RdBuff,
    output logic       Tx,
    output logic       Tx_ValidFrame,
    output logic       Tx_AbortedTrans,
    output logic       Tx_Done
);

    tx_state_t  state_q;
    logic [2:0] bit_q;      // index of the flag/data/abort bit on the line
    logic [7:0] byte_q;     // data byte being serialised
    logic       last_q;     // byte_q closes the frame
    logic       tx_q;
    logic       vf_q;
    logic       ab_q;
    logic       done_q;

    logic       stuff_req;
    logic       byte_end;   // this line bit is the final bit of the byte (incl. stuff)
    logic       pop_pt;     // a new byte is needed at the coming edge
    logic [2:0] nxt_bit;

    hdlc_zero_insert u_zins (
        .clk_i       (Clk),
        .rst_i       (Rst),
        .bit_i       (tx_q),
        .shift_en_i  (state_q == DATA),
        .clear_i     (state_q != DATA),
        .stuff_req_o (stuff_req)
    );

    // Pop-point decode; a byte is only taken when present and the frame is not aborting.
    always_comb begin
        nxt_bit  = bit_q + 3'd1;
        byte_end = ((state_q == DATA) && (bit_q == 3'd7) && !stuff_req) ||
                   ((state_q == STUFF) && (bit_q == 3'd7));
        pop_pt   = ((state_q == START_FLAG) && (bit_q == 3'd7)) || (byte_end && !last_q);
    end

    assign Tx_RdBuff = pop_pt && Tx_DataValid && !Tx_AbortFrame;

    // Framer FSM; every line/status output is the registered value for the next bit.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            bit_q   <= 3'd0;
            byte_q  <= 8'h00;
            last_q  <= 1'b0;
            tx_q    <= 1'b1;
            vf_q    <= 1'b0;
            ab_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (Tx_Enable && Tx_DataValid) begin
                        state_q <= START_FLAG;
                        bit_q   <= 3'd0;
                        tx_q    <= FLAG_BYTE[0];
                        vf_q    <= 1'b1;
                        ab_q    <= 1'b0;
                    end
                end
                START_FLAG, DATA, STUFF: begin
                    if (Tx_AbortFrame || (pop_pt && !Tx_DataValid)) begin
                        state_q <= ABORT;
                        bit_q   <= 3'd0;
                        tx_q    <= ABORT_BYTE[0];
                        vf_q    <= 1'b0;
                        ab_q    <= 1'b1;
                    end else if (pop_pt) begin
                        state_q <= DATA;
                        bit_q   <= 3'd0;
                        byte_q  <= Tx_Data;
                        last_q  <= Tx_Last;
                        tx_q    <= Tx_Data[0];
                    end else if (byte_end) begin
                        // only reached with last_q set
                        state_q <= END_FLAG;
                        bit_q   <= 3'd0;
                        tx_q    <= FLAG_BYTE[0];
                    end else if (state_q == START_FLAG) begin
                        bit_q <= nxt_bit;
                        tx_q  <= FLAG_BYTE[nxt_bit];
                    end else if (stuff_req) begin
                        // hold bit_q so the byte resumes at the right bit
                        state_q <= STUFF;
                        tx_q    <= 1'b0;
                    end else begin
                        state_q <= DATA;
                        bit_q   <= nxt_bit;
                        tx_q    <= byte_q[nxt_bit];
                    end
                end
                END_FLAG: begin
                    if (bit_q == 3'd7) begin
                        state_q <= IDLE;
                        tx_q    <= 1'b1;
                        vf_q    <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        bit_q <= nxt_bit;
                        tx_q  <= FLAG_BYTE[nxt_bit];
                    end
                end
                ABORT: begin
                    if (bit_q == 3'd7) begin
                        state_q <= IDLE;
                        tx_q    <= 1'b1;
                    end else begin
                        bit_q <= nxt_bit;
                        tx_q  <= ABORT_BYTE[nxt_bit];
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    vf_q    <= 1'b0;
                end
            endcase
        end
    end

    assign Tx              = tx_q;
    assign Tx_ValidFrame   = vf_q;
    assign Tx_AbortedTrans = ab_q;
    assign Tx_Done         = done_q;

endmodule
